// File: rtl/baggage_drop_pkg.sv
// Shared types, constants and helpers for the baggage_drop controller:
// FSM state encoding, seven-segment glyphs, 8.8 time type and sensor fusion.
package baggage_drop_pkg;

    // One result bit per iteration; 24-bit radicand gives a 12-bit root.
    localparam int ROOT_ITERS = 12;
    localparam int RAD_W      = 24;
    localparam int ROOT_W     = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROOT   = 2'd1,
        ST_FINISH = 2'd2
    } drop_state_e;

    // Unsigned 8.8 fixed-point time.
    typedef logic [15:0] time_8p8_t;

    // Seven-segment glyphs, bit0 = a ... bit6 = g, 1 = lit.
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_O     = 7'h5C;
    localparam logic [6:0] SEG_P     = 7'h73;
    localparam logic [6:0] SEG_C     = 7'h58;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_H     = 7'h76;
    localparam logic [6:0] SEG_T     = 7'h78;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Fuse four height readings; a zero reading marks a faulty sensor and
    // drops that diagonal pair. Sums are 10 bits wide so they never overflow.
    function automatic logic [7:0] fuse_height(input logic [7:0] s1,
                                               input logic [7:0] s2,
                                               input logic [7:0] s3,
                                               input logic [7:0] s4);
        logic [9:0] sum_v;
        logic [7:0] h_v;
        if (s1 == 8'd0 || s3 == 8'd0) begin
            sum_v = 10'(s2) + 10'(s4) + 10'd1;
            h_v   = 8'(sum_v >> 1);
        end else if (s2 == 8'd0 || s4 == 8'd0) begin
            sum_v = 10'(s1) + 10'(s3) + 10'd1;
            h_v   = 8'(sum_v >> 1);
        end else begin
            sum_v = 10'(s1) + 10'(s2) + 10'(s3) + 10'(s4) + 10'd2;
            h_v   = 8'(sum_v >> 2);
        end
        return h_v;
    endfunction

endpackage

// File: rtl/baggage_sqrt_iter.sv
// Sequential restoring square root: 24-bit radicand -> 12-bit floor root,
// one result bit per cycle, MSB first. `start` loads a new radicand; `done`
// is high during the cycle in which the final iteration is being performed,
// so `root` holds the finished result from the following cycle onwards.
module baggage_sqrt_iter
    import baggage_drop_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [RAD_W-1:0]    radicand,
    output logic [ROOT_W-1:0]   root,
    output logic                done
);

    logic [RAD_W-1:0]  rad_r;
    logic [13:0]       rem_r;
    logic [ROOT_W-1:0] root_r;
    logic [3:0]        cnt_r;
    logic              busy_r;

    logic [15:0]       rem_shift_s;
    logic [15:0]       trial_s;
    logic              fit_s;

    // Trial subtraction for the next radicand bit pair.
    always_comb begin
        rem_shift_s = {rem_r, rad_r[RAD_W-1:RAD_W-2]};
        trial_s     = {2'b00, root_r, 2'b01};
        fit_s       = (rem_shift_s >= trial_s);
    end

    // Iteration registers: load on start, then shift in one root bit per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rad_r  <= '0;
            rem_r  <= 14'd0;
            root_r <= '0;
            cnt_r  <= 4'd0;
            busy_r <= 1'b0;
        end else if (start) begin
            rad_r  <= radicand;
            rem_r  <= 14'd0;
            root_r <= '0;
            cnt_r  <= 4'd0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rad_r  <= {rad_r[RAD_W-3:0], 2'b00};
            rem_r  <= fit_s ? 14'(rem_shift_s - trial_s) : rem_shift_s[13:0];
            root_r <= {root_r[ROOT_W-2:0], fit_s};
            cnt_r  <= cnt_r + 4'd1;
            busy_r <= (cnt_r != 4'(ROOT_ITERS - 1));
        end
    end

    assign root = root_r;
    assign done = busy_r && (cnt_r == 4'(ROOT_ITERS - 1));

endmodule

// File: rtl/baggage_drop.sv
// Baggage-drop controller: fuses four height sensors, computes the fall time
// sqrt(h/2) in 8.8 fixed point with an iterative root, compares against the
// captured limit and drives a 4-digit message plus the drop command.
// Optional macro BAGGAGE_DROP_DEBUG_EN adds t_act_dbg and result_valid ports.
module baggage_drop
    import baggage_drop_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sensor1,
    input  logic [7:0]  sensor2,
    input  logic [7:0]  sensor3,
    input  logic [7:0]  sensor4,
    input  logic [15:0] t_lim,
    input  logic        drop_en,
    output logic [6:0]  seven_seg1,
    output logic [6:0]  seven_seg2,
    output logic [6:0]  seven_seg3,
    output logic [6:0]  seven_seg4,
    output logic        drop_activated
`ifdef BAGGAGE_DROP_DEBUG_EN
    ,
    output logic [15:0] t_act_dbg,
    output logic        result_valid
`endif
);

    drop_state_e       state_r;
    drop_state_e       state_next_s;
    logic              capture_s;
    logic              finish_s;

    logic [7:0]        h_s;
    logic [RAD_W-1:0]  radicand_s;
    logic [ROOT_W-1:0] root_s;
    logic              root_done_s;

    time_8p8_t         t_lim_r;
    logic              drop_en_r;
    time_8p8_t         t_act_s;
    logic [27:0]       msg_s;
    logic              drop_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: one sampling cycle, the root iterations, one update cycle.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE:   state_next_s = ST_ROOT;
            ST_ROOT:   state_next_s = root_done_s ? ST_FINISH : ST_ROOT;
            ST_FINISH: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: capture in IDLE, publish in FINISH.
    always_comb begin
        capture_s = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            ST_IDLE:   capture_s = 1'b1;
            ST_FINISH: finish_s  = 1'b1;
            default: begin
                capture_s = 1'b0;
                finish_s  = 1'b0;
            end
        endcase
    end

    // Fused height; radicand is h/2 carrying 16 fractional bits.
    always_comb begin
        h_s        = fuse_height(sensor1, sensor2, sensor3, sensor4);
        radicand_s = {1'b0, h_s, 15'd0};
    end

    baggage_sqrt_iter u_sqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (capture_s),
        .radicand (radicand_s),
        .root     (root_s),
        .done     (root_done_s)
    );

    // Capture the limit and operator request alongside the sensor sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_lim_r   <= 16'd0;
            drop_en_r <= 1'b0;
        end else if (capture_s) begin
            t_lim_r   <= t_lim;
            drop_en_r <= drop_en;
        end
    end

    // Message selection; equality with the limit counts as within limit.
    always_comb begin
        t_act_s = {4'h0, root_s};
        if (t_act_s > t_lim_r) begin
            msg_s  = {SEG_BLANK, SEG_H, SEG_O, SEG_T};
            drop_s = 1'b0;
        end else if (drop_en_r) begin
            msg_s  = {SEG_D, SEG_R, SEG_O, SEG_P};
            drop_s = 1'b1;
        end else begin
            msg_s  = {SEG_C, SEG_O, SEG_L, SEG_D};
            drop_s = 1'b0;
        end
    end

    // Outputs update together in FINISH and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            seven_seg1     <= SEG_BLANK;
            seven_seg2     <= SEG_BLANK;
            seven_seg3     <= SEG_BLANK;
            seven_seg4     <= SEG_BLANK;
            drop_activated <= 1'b0;
        end else if (finish_s) begin
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <= msg_s;
            drop_activated <= drop_s;
        end
    end

`ifdef BAGGAGE_DROP_DEBUG_EN
    // Debug view: last computed time and a pulse marking each new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_act_dbg    <= 16'd0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= finish_s;
            if (finish_s) begin
                t_act_dbg <= t_act_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_baggage_drop.sv
// Self-checking bench for baggage_drop: directed vectors plus random ones,
// checked every cycle against a behavioural model of the fall-time rules.
module tb_baggage_drop;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sensor1, sensor2, sensor3, sensor4;
    logic [15:0] t_lim;
    logic        drop_en;
    logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;
    logic        drop_activated;
`ifdef BAGGAGE_DROP_DEBUG_EN
    logic [15:0] t_act_dbg;
    logic        result_valid;
`endif

    always #5 clk = ~clk;

    baggage_drop dut (
        .clk            (clk),
        .rst            (rst),
        .sensor1        (sensor1),
        .sensor2        (sensor2),
        .sensor3        (sensor3),
        .sensor4        (sensor4),
        .t_lim          (t_lim),
        .drop_en        (drop_en),
        .seven_seg1     (seven_seg1),
        .seven_seg2     (seven_seg2),
        .seven_seg3     (seven_seg3),
        .seven_seg4     (seven_seg4),
        .drop_activated (drop_activated)
`ifdef BAGGAGE_DROP_DEBUG_EN
        ,
        .t_act_dbg      (t_act_dbg),
        .result_valid   (result_valid)
`endif
    );

    localparam logic [27:0] MSG_DROP = {7'h5E, 7'h50, 7'h5C, 7'h73};
    localparam logic [27:0] MSG_HOT  = {7'h00, 7'h76, 7'h5C, 7'h78};
    localparam logic [27:0] MSG_COLD = {7'h58, 7'h5C, 7'h38, 7'h5E};
    localparam int PERIOD = 14;

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    function automatic int model_h(int s1, int s2, int s3, int s4);
        if (s1 == 0 || s3 == 0) return (s2 + s4 + 1) / 2;
        if (s2 == 0 || s4 == 0) return (s1 + s3 + 1) / 2;
        return (s1 + s2 + s3 + s4 + 2) / 4;
    endfunction

    function automatic int isqrt(int r);
        int x = 0;
        while ((x + 1) * (x + 1) <= r) x++;
        return x;
    endfunction

    // t_act in 8.8: sqrt(h/2) * 256 = floor(sqrt(h * 32768)).
    function automatic int model_tact(int s1, int s2, int s3, int s4);
        return isqrt(model_h(s1, s2, s3, s4) * 32768);
    endfunction

    function automatic logic [28:0] model_out(int tact, int tlim, logic den);
        if (tact > tlim) return {1'b0, MSG_HOT};
        if (den)         return {1'b1, MSG_DROP};
        return {1'b0, MSG_COLD};
    endfunction

    int          edge_cnt;
    logic [28:0] exp_out, pend_out;
    int          exp_tact, pend_tact;
    logic        exp_rv;
    bit          live = 1'b0;

    // Model: a sample every PERIOD edges from reset release, result visible
    // PERIOD-1 edges after its sample.
    always @(posedge clk) begin
        if (rst) begin
            edge_cnt  <= 0;
            exp_out   <= 29'd0;
            pend_out  <= 29'd0;
            exp_tact  <= 0;
            pend_tact <= 0;
            exp_rv    <= 1'b0;
            live      <= 1'b1;
        end else begin
            if (edge_cnt % PERIOD == 0) begin
                pend_tact <= model_tact(sensor1, sensor2, sensor3, sensor4);
                pend_out  <= model_out(model_tact(sensor1, sensor2, sensor3, sensor4),
                                       int'(t_lim), drop_en);
            end
            if (edge_cnt % PERIOD == PERIOD - 1) begin
                exp_out  <= pend_out;
                exp_tact <= pend_tact;
                exp_rv   <= 1'b1;
            end else begin
                exp_rv   <= 1'b0;
            end
            edge_cnt <= edge_cnt + 1;
        end
    end

    // ---------------- compare process ----------------
    int          lit_seq = 0;
    int          lit_seen = 0;
    logic [28:0] lit_out;
    string       lit_name;
    bit          pins_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            check("msg", {4'h0, seven_seg1, seven_seg2, seven_seg3, seven_seg4}, {4'h0, exp_out[27:0]});
            check("drop_activated", {31'd0, drop_activated}, {31'd0, exp_out[28]});
`ifdef BAGGAGE_DROP_DEBUG_EN
            check("t_act_dbg", {16'd0, t_act_dbg}, exp_tact);
            check("result_valid", {31'd0, result_valid}, {31'd0, exp_rv});
`endif
        end
        if (lit_seq != lit_seen) begin
            check({lit_name, "_msg"}, {4'h0, seven_seg1, seven_seg2, seven_seg3, seven_seg4},
                  {4'h0, lit_out[27:0]});
            check({lit_name, "_drop"}, {31'd0, drop_activated}, {31'd0, lit_out[28]});
            lit_seen = lit_seq;
        end
        if (live && !pins_done) begin
            check("pin_h_all", model_h(100, 100, 100, 100), 100);
            check("pin_t_100", model_tact(100, 100, 100, 100), 32'h0712);
            check("pin_h_fault1", model_h(0, 1, 9, 3), 2);
            check("pin_t_fault1", model_tact(0, 1, 9, 3), 32'h0100);
            check("pin_h_fault2", model_h(4, 0, 5, 200), 5);
            check("pin_t_max", model_tact(255, 255, 255, 255), 32'h0B4A);
            check("pin_t_zero", model_tact(0, 0, 0, 0), 0);
            pins_done = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic scramble();
        sensor1 = 8'($urandom);
        sensor2 = 8'($urandom);
        sensor3 = 8'($urandom);
        sensor4 = 8'($urandom);
        t_lim   = 16'($urandom);
        drop_en = 1'($urandom);
    endtask

    task automatic post_lit(input string name, input logic [28:0] o);
        lit_name = name;
        lit_out  = o;
        lit_seq++;
    endtask

    // Hold a vector over its sample edge, scramble inputs during the root,
    // and optionally pin the published result to a literal.
    task automatic run_period(input int s1, input int s2, input int s3, input int s4,
                              input int tl, input logic den,
                              input bit lit, input string name, input logic [28:0] lo);
        sensor1 = 8'(s1);
        sensor2 = 8'(s2);
        sensor3 = 8'(s3);
        sensor4 = 8'(s4);
        t_lim   = 16'(tl);
        drop_en = den;
        @(posedge clk);
        for (int k = 1; k < PERIOD; k++) begin
            #1 scramble();
            @(posedge clk);
        end
        #1;
        if (lit) post_lit(name, lo);
    endtask

    function automatic int rand_sensor();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
    endfunction

    initial begin
        rst = 1'b1;
        sensor1 = 8'd0; sensor2 = 8'd0; sensor3 = 8'd0; sensor4 = 8'd0;
        t_lim = 16'd0; drop_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 post_lit("reset", 29'd0);
        rst = 1'b0;

        run_period(100, 100, 100, 100, 16'h0712, 1'b1, 1'b1, "dir_drop", {1'b1, MSG_DROP});
        run_period(100, 100, 100, 100, 16'h0711, 1'b1, 1'b1, "dir_hot", {1'b0, MSG_HOT});
        run_period(0, 1, 9, 3, 16'h0100, 1'b1, 1'b1, "dir_fault1", {1'b1, MSG_DROP});
        run_period(4, 0, 5, 200, 16'h0194, 1'b0, 1'b1, "dir_fault2", {1'b0, MSG_COLD});
        run_period(4, 0, 5, 200, 16'h0193, 1'b1, 1'b1, "dir_fault2_hot", {1'b0, MSG_HOT});
        run_period(0, 0, 0, 0, 16'h0000, 1'b0, 1'b1, "dir_zero_cold", {1'b0, MSG_COLD});
        run_period(0, 0, 0, 0, 16'h0000, 1'b1, 1'b1, "dir_zero_drop", {1'b1, MSG_DROP});
        run_period(255, 255, 255, 255, 16'hFFFF, 1'b1, 1'b1, "dir_max", {1'b1, MSG_DROP});

        // Reset in the middle of the root iterations.
        sensor1 = 8'd50; sensor2 = 8'd60; sensor3 = 8'd70; sensor4 = 8'd80;
        t_lim = 16'h0000; drop_en = 1'b1;
        @(posedge clk);
        repeat (5) begin
            #1 scramble();
            @(posedge clk);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1 post_lit("mid_reset", 29'd0);
        rst = 1'b0;
        run_period(100, 100, 100, 100, 16'h0800, 1'b1, 1'b1, "post_reset", {1'b1, MSG_DROP});

        repeat (40) begin
            int s1, s2, s3, s4, ta, tl;
            s1 = rand_sensor(); s2 = rand_sensor(); s3 = rand_sensor(); s4 = rand_sensor();
            ta = model_tact(s1, s2, s3, s4);
            case ($urandom_range(0, 4))
                0:       tl = int'($urandom_range(0, 16'hFFFF));
                1:       tl = ta;
                2:       tl = (ta > 0) ? ta - 1 : 0;
                3:       tl = ta + 1;
                default: tl = 16'hFFFF;
            endcase
            run_period(s1, s2, s3, s4, tl, 1'($urandom), 1'b0, "rand", 29'd0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
